// File: rtl/spi_master_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_bus_pkg
//  Description : Shared constants for the byte-wide SPI master. This covers the
//                SPI mode, the transfer width and the controller state
//                encoding. It also holds a helper that sizes the divider
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_master_bus_pkg;

    // SPI mode 0: SCLK idles low, data is sampled on the rising edge.
    localparam logic       c_CPOL     = 1'b0;
    localparam int         c_DATA_W   = 8;
    localparam logic [3:0] c_BITS     = 4'd8;

    // Controller states
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_XFER  = 1'b1;

    // Counter width able to hold 0..v-1; never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_bus_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_div
//  Description : SCLK half-period counter. While enabled, it raises a one-clock
//                strobe every HALF_DIV clocks. The current SCLK level decides
//                which strobe fires: rise is the strobe for a 0->1 toggle and
//                fall is the strobe for a 1->0 toggle.
//  Ports       : clk, reset - system clock / synchronous active-high reset
//                en         - count only while a transfer is running
//                sclk       - present registered SCLK level
//                rise, fall - toggle strobes (mutually exclusive)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import spi_master_bus_pkg::*;
#(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sclk,
    output logic rise,
    output logic fall
);

    localparam int c_CW = cnt_width(HALF_DIV);

    logic [c_CW-1:0] r_cnt;
    logic            w_tick;

    assign w_tick = en && (r_cnt == c_CW'(HALF_DIV - 1));
    assign rise   = w_tick & ~sclk;
    assign fall   = w_tick &  sclk;

    // Held at zero outside a transfer so every transfer starts on a full
    // half-period.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_bus.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_bus
//  Description : Byte-wide SPI master in mode 0, MSB first. A falling edge on
//                nwr starts one full-duplex transfer of data_tx. The received
//                byte appears on data_rx when the transfer ends.
//  Ports       : clk, reset - system clock / synchronous active-high reset
//                nwr        - active-low write strobe (falling edge = start)
//                data_tx    - byte to send, taken on the start clock
//                data_rx    - last received byte
//                spi_busy   - transfer in progress
//                spi_cs     - active-low slave select
//                spi_clk    - SCLK, idle low
//                spi_mosi   - serial out, MSB first
//                spi_miso   - serial in
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_bus
    import spi_master_bus_pkg::*;
#(
    parameter int HALF_DIV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nwr,
    input  logic [c_DATA_W-1:0] data_tx,
    output logic [c_DATA_W-1:0] data_rx,
    output logic                spi_busy,
    output logic                spi_cs,
    output logic                spi_clk,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    logic [0:0]          r_state, w_state;
    logic                r_nwr_d;
    // Bit 7 goes straight onto MOSI at start, so only the remaining
    // seven bits are kept.
    logic [c_DATA_W-2:0] r_tx_rest, w_tx_rest;
    logic [c_DATA_W-1:0] r_rx_shift, w_rx_shift;
    logic [3:0]          r_bit_cnt, w_bit_cnt;
    logic [c_DATA_W-1:0] r_data_rx, w_data_rx;
    logic                r_busy, w_busy;
    logic                r_cs, w_cs;
    logic                r_sclk, w_sclk;
    logic                r_mosi, w_mosi;

    logic w_start;
    logic w_rise;
    logic w_fall;

    assign w_start = r_nwr_d & ~nwr;

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == c_ST_XFER),
        .sclk  (r_sclk),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_comb begin
        w_state    = r_state;
        w_tx_rest  = r_tx_rest;
        w_rx_shift = r_rx_shift;
        w_bit_cnt  = r_bit_cnt;
        w_data_rx  = r_data_rx;
        w_busy     = r_busy;
        w_cs       = r_cs;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;

        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state    = c_ST_XFER;
                    w_tx_rest  = data_tx[c_DATA_W-2:0];
                    w_rx_shift = '0;
                    w_bit_cnt  = c_BITS;
                    w_busy     = 1'b1;
                    w_cs       = 1'b0;
                    w_sclk     = c_CPOL;
                    w_mosi     = data_tx[c_DATA_W-1];
                end
            end
            c_ST_XFER: begin
                // Starts seen here are dropped and are not queued.
                if (w_rise) begin
                    w_sclk     = 1'b1;
                    w_rx_shift = {r_rx_shift[c_DATA_W-2:0], spi_miso};
                end
                if (w_fall) begin
                    w_sclk    = 1'b0;
                    w_mosi    = r_tx_rest[c_DATA_W-2];
                    w_tx_rest = {r_tx_rest[c_DATA_W-3:0], 1'b0};
                    w_bit_cnt = r_bit_cnt - 4'd1;
                    if (r_bit_cnt == 4'd1) begin
                        // The eighth falling edge ends the transfer. All 8
                        // bits were sampled on the preceding rising edges.
                        w_state   = c_ST_IDLE;
                        w_busy    = 1'b0;
                        w_cs      = 1'b1;
                        w_mosi    = 1'b0;
                        w_data_rx = r_rx_shift;
                    end
                end
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_nwr_d    <= 1'b1;
            r_tx_rest  <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_data_rx  <= '0;
            r_busy     <= 1'b0;
            r_cs       <= 1'b1;
            r_sclk     <= c_CPOL;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_nwr_d    <= nwr;
            r_tx_rest  <= w_tx_rest;
            r_rx_shift <= w_rx_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_data_rx  <= w_data_rx;
            r_busy     <= w_busy;
            r_cs       <= w_cs;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
        end
    end

    assign data_rx  = r_data_rx;
    assign spi_busy = r_busy;
    assign spi_cs   = r_cs;
    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_bus
//  Description : Directed self-checking bench for spi_master_bus. It uses one
//                instance with HALF_DIV=1 and one instance with HALF_DIV=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_bus;

    logic       clk = 1'b0;
    logic       reset;
    // HALF_DIV = 1 instance
    logic       nwr, spi_miso;
    logic [7:0] data_tx, data_rx;
    logic       spi_busy, spi_cs, spi_clk, spi_mosi;
    // HALF_DIV = 3 instance
    logic       nwr3, spi_miso3;
    logic [7:0] data_tx3, data_rx3;
    logic       spi_busy3, spi_cs3, spi_clk3, spi_mosi3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_master_bus #(.HALF_DIV(1)) dut (
        .clk(clk), .reset(reset), .nwr(nwr), .data_tx(data_tx), .data_rx(data_rx),
        .spi_busy(spi_busy), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_master_bus #(.HALF_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .nwr(nwr3), .data_tx(data_tx3), .data_rx(data_rx3),
        .spi_busy(spi_busy3), .spi_cs(spi_cs3), .spi_clk(spi_clk3),
        .spi_mosi(spi_mosi3), .spi_miso(spi_miso3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nwr(input bit h3, input logic v);
        if (h3) nwr3 = v; else nwr = v;
    endtask

    task automatic set_miso(input bit h3, input logic v);
        if (h3) spi_miso3 = v; else spi_miso = v;
    endtask

    // Launches one transfer from a post-edge point and follows it to cs high.
    // It acts as a mode-0 slave: it presents miso_byte MSB first and changes
    // MISO after each SCLK fall. It captures MOSI while SCLK is high.
    // inject_cyc >= 0 pulses nwr low again mid-transfer with data 0xFF.
    task automatic run_xfer(input bit h3, input string tag, input logic [7:0] tx,
                            input logic [7:0] miso_byte, input int inject_cyc,
                            input bit hold, output logic [7:0] cap, output int pulses,
                            output int cs_low, output int first_rise);
        int   cyc;
        int   idx;
        logic prev;
        logic o_cs, o_busy, o_sclk, o_mosi;
        if (h3) data_tx3 = tx; else data_tx = tx;
        idx = 7;
        set_miso(h3, miso_byte[idx]);
        set_nwr(h3, 1'b0);
        step();
        if (!hold) set_nwr(h3, 1'b1);
        cap = '0; pulses = 0; cs_low = 0; first_rise = -1; prev = 1'b0; cyc = 0;
        while (cyc < 400) begin
            o_cs   = h3 ? spi_cs3   : spi_cs;
            o_busy = h3 ? spi_busy3 : spi_busy;
            o_sclk = h3 ? spi_clk3  : spi_clk;
            o_mosi = h3 ? spi_mosi3 : spi_mosi;
            if (cyc == 0) begin
                check({tag, "_start_busy"}, {31'd0, o_busy}, 32'd1);
                check({tag, "_start_cs"},   {31'd0, o_cs},   32'd0);
                check({tag, "_start_sclk"}, {31'd0, o_sclk}, 32'd0);
                check({tag, "_start_mosi"}, {31'd0, o_mosi}, {31'd0, tx[7]});
            end
            if (o_cs) break;
            cs_low++;
            if (o_sclk && !prev) begin
                cap = {cap[6:0], o_mosi};
                pulses++;
                if (first_rise < 0) first_rise = cyc;
            end
            if (!o_sclk && prev) begin
                idx--;
                if (idx >= 0) set_miso(h3, miso_byte[idx]);
            end
            prev = o_sclk;
            if (!hold && cyc == inject_cyc) begin
                if (h3) data_tx3 = 8'hFF; else data_tx = 8'hFF;
                set_nwr(h3, 1'b0);
            end else if (!hold && cyc == inject_cyc + 1) begin
                set_nwr(h3, 1'b1);
            end
            step();
            cyc++;
        end
        check({tag, "_timeout"}, {31'd0, (cyc >= 400)}, 32'd0);
    endtask

    initial begin
        logic [7:0] cap;
        int         pulses, cs_low, first_rise;
        logic       seen_busy;

        reset = 1'b1;
        nwr = 1'b1; data_tx = 8'h00; spi_miso = 1'b0;
        nwr3 = 1'b1; data_tx3 = 8'h00; spi_miso3 = 1'b0;

        // 1: reset held two clocks
        step();
        step();
        check("rst_cs",      {31'd0, spi_cs},   32'd1);
        check("rst_busy",    {31'd0, spi_busy}, 32'd0);
        check("rst_sclk",    {31'd0, spi_clk},  32'd0);
        check("rst_mosi",    {31'd0, spi_mosi}, 32'd0);
        check("rst_data_rx", {24'd0, data_rx},  32'h00);
        check("rst_cs3",     {31'd0, spi_cs3},  32'd1);
        reset = 1'b0;
        step();
        step();

        // 2/3: 0xAA out, miso 0,1,0,1,1,0,1,0 in
        run_xfer(1'b0, "t2", 8'hAA, 8'h5A, -10, 1'b0, cap, pulses, cs_low, first_rise);
        check("t2_mosi_bits",  {24'd0, cap}, 32'hAA);
        check("t2_pulses",     pulses,       32'd8);
        check("t2_cs_low",     cs_low,       32'd16);
        check("t2_first_rise", first_rise,   32'd1);
        check("t3_data_rx",    {24'd0, data_rx}, 32'h5A);
        check("t3_end_busy",   {31'd0, spi_busy}, 32'd0);
        check("t3_end_sclk",   {31'd0, spi_clk},  32'd0);
        check("t3_end_mosi",   {31'd0, spi_mosi}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            spi_miso = ~spi_miso;
            step();
        end
        check("t3_rx_held", {24'd0, data_rx}, 32'h5A);

        // 4: second start mid-transfer with 0xFF is ignored
        run_xfer(1'b0, "t4", 8'hAA, 8'h3C, 5, 1'b0, cap, pulses, cs_low, first_rise);
        check("t4_mosi_bits", {24'd0, cap}, 32'hAA);
        check("t4_pulses",    pulses,       32'd8);
        check("t4_cs_low",    cs_low,       32'd16);
        check("t4_data_rx",   {24'd0, data_rx}, 32'h3C);
        step();
        check("t4_no_queue",  {31'd0, spi_busy}, 32'd0);

        // Back-to-back: start on the very clock busy drops
        run_xfer(1'b0, "bb", 8'h81, 8'h00, -10, 1'b0, cap, pulses, cs_low, first_rise);
        begin : b2b
            run_xfer(1'b0, "bb2", 8'h7E, 8'hE7, -10, 1'b0, cap, pulses, cs_low, first_rise);
        end
        check("bb2_mosi_bits", {24'd0, cap}, 32'h7E);
        check("bb2_data_rx",   {24'd0, data_rx}, 32'hE7);

        // 5: nwr held low for about 40 clocks -> one transfer only
        run_xfer(1'b0, "t5", 8'h96, 8'hC3, -10, 1'b1, cap, pulses, cs_low, first_rise);
        check("t5_mosi_bits", {24'd0, cap}, 32'h96);
        check("t5_data_rx",   {24'd0, data_rx}, 32'hC3);
        seen_busy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (spi_busy) seen_busy = 1'b1;
            step();
        end
        check("t5_no_retrigger", {31'd0, seen_busy}, 32'd0);
        nwr = 1'b1;
        step();

        // 6: reset at the 4th SCLK pulse aborts the transfer
        data_tx = 8'h0F;
        spi_miso = 1'b1;
        nwr = 1'b0;
        step();
        nwr = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (spi_clk && !cap[0]) pulses++;
            cap[0] = spi_clk;
            if (pulses == 4) break;
            step();
        end
        check("t6_reached_pulse4", pulses, 32'd4);
        reset = 1'b1;
        step();
        check("t6_cs",      {31'd0, spi_cs},   32'd1);
        check("t6_busy",    {31'd0, spi_busy}, 32'd0);
        check("t6_sclk",    {31'd0, spi_clk},  32'd0);
        check("t6_mosi",    {31'd0, spi_mosi}, 32'd0);
        check("t6_data_rx", {24'd0, data_rx},  32'h00);
        reset = 1'b0;
        step();
        step();
        check("t6_stays_idle", {31'd0, spi_busy}, 32'd0);

        // HALF_DIV = 3: SCLK period is 6 clks and cs is low for 48 clks
        run_xfer(1'b1, "h3", 8'h5C, 8'hA5, -10, 1'b0, cap, pulses, cs_low, first_rise);
        check("h3_mosi_bits",  {24'd0, cap}, 32'h5C);
        check("h3_pulses",     pulses,       32'd8);
        check("h3_cs_low",     cs_low,       32'd48);
        check("h3_first_rise", first_rise,   32'd3);
        check("h3_data_rx",    {24'd0, data_rx3}, 32'hA5);
        check("h3_end_busy",   {31'd0, spi_busy3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
